// File: rtl/arc4_pkg.sv
// Shared ARC4 types and constants used by the ksa and prga stages.
package arc4_pkg;

    localparam int S_DEPTH   = 256;
    localparam int KEY_BYTES = 3;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        RD_I = 3'd2,
        LD_I = 3'd3,
        RD_J = 3'd4,
        LD_J = 3'd5,
        WR_I = 3'd6,
        WR_J = 3'd7
    } ksa_state_t;

    // Key byte index wraps 0-1-2 without a divider.
    function automatic logic [1:0] k_next(input logic [1:0] k);
        return (k == 2'd2) ? 2'd0 : k + 2'd1;
    endfunction

endpackage

// File: rtl/ksa_if.sv
// en/rdy handshake plus single-port S-memory bus between ksa and its environment.
interface ksa_if;
    import arc4_pkg::*;

    logic        en;
    logic        rdy;
    logic [23:0] key;
    byte_t       addr;
    byte_t       rddata;
    byte_t       wrdata;
    logic        wren;

    modport slave  (input  en, key, rddata, output rdy, addr, wrdata, wren);
    modport master (output en, key, rddata, input  rdy, addr, wrdata, wren);

endinterface

// File: rtl/arc4_key_byte_sel.sv
// Selects key byte k from a 24-bit ARC4 key; byte 0 is the most significant.
module arc4_key_byte_sel
    import arc4_pkg::*;
(
    input  logic [23:0] i_key,
    input  logic [1:0]  i_k,
    output byte_t       o_key_byte
);

    // 3:1 byte mux
    always_comb begin
        case (i_k)
            2'd0:    o_key_byte = i_key[23:16];
            2'd1:    o_key_byte = i_key[15:8];
            2'd2:    o_key_byte = i_key[7:0];
            default: o_key_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes S in a registered-address RAM using a 24-bit key.
// Build option KSA_SELFINIT_EN adds a 256-cycle identity fill of S before scheduling.
module ksa
    import arc4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    ksa_if.slave  bus
);

    ksa_state_t  r_state, w_state_nxt;
    byte_t       r_i, r_j, r_si, r_sj;
    byte_t       w_i_nxt, w_j_nxt, w_si_nxt, w_sj_nxt;
    logic [1:0]  r_k, w_k_nxt;
    logic [23:0] r_key, w_key_nxt;
    byte_t       r_addr, r_wrdata, w_addr_nxt, w_wrdata_nxt;
    logic        r_wren, r_rdy, w_wren_nxt, w_rdy_nxt;
    byte_t       w_key_byte;

    arc4_key_byte_sel u_key_sel (
        .i_key      (r_key),
        .i_k        (r_k),
        .o_key_byte (w_key_byte)
    );

    // State register and datapath registers; outputs are registered versions of the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_i      <= 8'h00;
            r_j      <= 8'h00;
            r_k      <= 2'd0;
            r_si     <= 8'h00;
            r_sj     <= 8'h00;
            r_key    <= 24'h000000;
            r_addr   <= 8'h00;
            r_wrdata <= 8'h00;
            r_wren   <= 1'b0;
            r_rdy    <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_k      <= w_k_nxt;
            r_si     <= w_si_nxt;
            r_sj     <= w_sj_nxt;
            r_key    <= w_key_nxt;
            r_addr   <= w_addr_nxt;
            r_wrdata <= w_wrdata_nxt;
            r_wren   <= w_wren_nxt;
            r_rdy    <= w_rdy_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_k_nxt     = r_k;
        w_si_nxt    = r_si;
        w_sj_nxt    = r_sj;
        w_key_nxt   = r_key;
        case (r_state)
            IDLE: begin
                if (bus.en) begin
                    w_key_nxt = bus.key;
                    w_i_nxt   = 8'h00;
                    w_j_nxt   = 8'h00;
                    w_k_nxt   = 2'd0;
`ifdef KSA_SELFINIT_EN
                    w_state_nxt = INIT;
`else
                    w_state_nxt = RD_I;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            INIT: begin
                // i doubles as the fill counter and wraps back to 0 for scheduling
                w_i_nxt = r_i + 8'h01;
                if (r_i == 8'hFF) begin
                    w_state_nxt = RD_I;
                end else begin
                    w_state_nxt = INIT;
                end
            end
            RD_I: w_state_nxt = LD_I;
            LD_I: begin
                w_si_nxt    = bus.rddata;
                w_j_nxt     = r_j + bus.rddata + w_key_byte;
                w_state_nxt = RD_J;
            end
            RD_J: w_state_nxt = LD_J;
            LD_J: begin
                w_sj_nxt    = bus.rddata;
                w_state_nxt = WR_I;
            end
            WR_I: w_state_nxt = WR_J;
            WR_J: begin
                if (r_i == 8'hFF) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_i_nxt     = r_i + 8'h01;
                    w_k_nxt     = k_next(r_k);
                    w_state_nxt = RD_I;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bus values to present while in the next state
    always_comb begin
        w_addr_nxt   = 8'h00;
        w_wrdata_nxt = 8'h00;
        w_wren_nxt   = 1'b0;
        w_rdy_nxt    = 1'b0;
        case (w_state_nxt)
            IDLE: w_rdy_nxt = 1'b1;
            INIT: begin
                w_addr_nxt   = w_i_nxt;
                w_wrdata_nxt = w_i_nxt;
                w_wren_nxt   = 1'b1;
            end
            RD_I: w_addr_nxt = w_i_nxt;
            LD_I: w_addr_nxt = w_i_nxt;
            RD_J: w_addr_nxt = w_j_nxt;
            LD_J: w_addr_nxt = w_j_nxt;
            WR_I: begin
                w_addr_nxt   = w_i_nxt;
                w_wrdata_nxt = w_sj_nxt;
                w_wren_nxt   = 1'b1;
            end
            WR_J: begin
                w_addr_nxt   = w_j_nxt;
                w_wrdata_nxt = w_si_nxt;
                w_wren_nxt   = 1'b1;
            end
            default: w_rdy_nxt = 1'b1;
        endcase
    end

    assign bus.rdy    = r_rdy;
    assign bus.addr   = r_addr;
    assign bus.wrdata = r_wrdata;
    assign bus.wren   = r_wren;

endmodule

// File: tb/tb_ksa.sv
// Directed self-checking bench for ksa with a registered-address S RAM and a reference KSA model.
module tb_ksa;
    import arc4_pkg::*;

`ifdef KSA_SELFINIT_EN
    localparam int LAT = 1793;
    localparam int NWR = 768;
    localparam int OFF = 256;
`else
    localparam int LAT = 1537;
    localparam int NWR = 512;
    localparam int OFF = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ksa_if bus ();
    ksa dut (.clk(clk), .rst(rst), .bus(bus));

    byte_t mem [256];
    byte_t ld_val [256];
    byte_t ms [256];
    logic  ld = 1'b0;
    logic [15:0] wlog [$];
    int n_cmp = 0;
    int n_mism = 0;

    // S RAM: registered address, bulk preload when ld is high
    always @(posedge clk) begin
        if (ld) begin
            for (int a = 0; a < 256; a++) mem[a] <= ld_val[a];
        end else if (bus.wren) begin
            mem[bus.addr] <= bus.wrdata;
        end
        bus.rddata <= mem[bus.addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mism++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit identity, input byte_t fill);
        for (int a = 0; a < 256; a++) ld_val[a] = identity ? byte_t'(a) : fill;
        ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
    endtask

    task automatic model_from_mem();
`ifdef KSA_SELFINIT_EN
        for (int a = 0; a < 256; a++) ms[a] = byte_t'(a);
`else
        for (int a = 0; a < 256; a++) ms[a] = mem[a];
`endif
    endtask

    task automatic model_run(input logic [23:0] kk);
        byte_t j, t, kb;
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            kb = byte_t'(kk >> (8 * (2 - (i % 3))));
            j = j + ms[i] + kb;
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
        end
    endtask

    task automatic check_final(input string tag);
        int bad;
        int dup;
        bit seen [256];
        bad = 0;
        dup = 0;
        for (int a = 0; a < 256; a++) seen[a] = 1'b0;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== ms[a]) bad++;
            if (seen[mem[a]]) dup++;
            seen[mem[a]] = 1'b1;
        end
        chk({tag, "_s"}, bad, 0);
        chk({tag, "_perm"}, dup, 0);
    endtask

    // Accept a run, log writes each cycle, return the cycle index where rdy is seen high again
    task automatic run_pass(input logic [23:0] kk, input bit wiggle, input int abort_at, output int cyc);
        bus.key = kk;
        bus.en  = 1'b1;
        @(posedge clk); #1;
        bus.en  = 1'b0;
        chk("rdy_drop", bus.rdy, 0);
        wlog.delete();
        cyc = 1;
        while (bus.rdy == 1'b0 && cyc < 4000) begin
            if (abort_at > 0 && cyc == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                chk("abort_rdy", bus.rdy, 1);
                chk("abort_wren", bus.wren, 0);
                break;
            end
            if (bus.wren) wlog.push_back({bus.addr, bus.wrdata});
            if (wiggle) begin
                bus.en  = $urandom_range(0, 1);
                bus.key = $urandom;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.en  = 1'b0;
        bus.key = kk;
    endtask

    function automatic logic [15:0] wlog_at(input int idx);
        return (idx < wlog.size()) ? wlog[idx] : 16'hFFFF;
    endfunction

    initial begin
        int cyc;
        logic [15:0] fw [6];
        fw[0] = 16'h0000; fw[1] = 16'h0000; fw[2] = 16'h0101;
        fw[3] = 16'h0101; fw[4] = 16'h0203; fw[5] = 16'h0302;
        bus.en  = 1'b0;
        bus.key = 24'h000000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rdy", bus.rdy, 1);
        chk("rst_wren", bus.wren, 0);
        chk("rst_addr", bus.addr, 0);
        chk("rst_wrdata", bus.wrdata, 0);

        // zero key: latency, write count, first iterations, final S
        preload(1'b1, 8'h00);
        model_from_mem();
        model_run(24'h000000);
        run_pass(24'h000000, 1'b0, 0, cyc);
        chk("lat_k0", cyc, LAT);
        chk("nwr_k0", wlog.size(), NWR);
        for (int n = 0; n < 6; n++) chk("first_wr", wlog_at(OFF + n), fw[n]);
        check_final("k0");

        // key byte 0 is the most significant byte
        preload(1'b1, 8'h00);
        model_from_mem();
        model_run(24'h010000);
        run_pass(24'h010000, 1'b0, 0, cyc);
        chk("kord_wr0", wlog_at(OFF), 16'h0001);
        chk("kord_wr1", wlog_at(OFF + 1), 16'h0100);
        check_final("k010000");

        preload(1'b1, 8'h00);
        model_from_mem();
        model_run(24'h1E4600);
        run_pass(24'h1E4600, 1'b0, 0, cyc);
        check_final("k1E4600");

        preload(1'b1, 8'h00);
        model_from_mem();
        model_run(24'hFFFFFF);
        run_pass(24'hFFFFFF, 1'b0, 0, cyc);
        check_final("kFFFFFF");

        // reset mid-run, then a fresh run over the partially scrambled S
        preload(1'b1, 8'h00);
        run_pass(24'h1E4600, 1'b0, 700, cyc);
        model_from_mem();
        model_run(24'hFFFFFF);
        run_pass(24'hFFFFFF, 1'b0, 0, cyc);
        chk("lat_after_rst", cyc, LAT);
        check_final("after_rst");

        // en and key wiggled while busy: no restart, no extra writes
        preload(1'b1, 8'h00);
        model_from_mem();
        model_run(24'h1E4600);
        run_pass(24'h1E4600, 1'b1, 0, cyc);
        chk("lat_wiggle", cyc, LAT);
        chk("nwr_wiggle", wlog.size(), NWR);
        check_final("wiggle");
        @(posedge clk); #1;
        chk("idle_after_wiggle", bus.rdy, 1);

`ifdef KSA_SELFINIT_EN
        preload(1'b0, 8'hAA);
        model_from_mem();
        model_run(24'h1E4600);
        run_pass(24'h1E4600, 1'b0, 0, cyc);
        chk("lat_selfinit", cyc, LAT);
        check_final("selfinit_aa");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
        $finish;
    end

endmodule
